// File: rtl/mux_scan_collector.sv
// mux_scan_collector: walks the 32:1 bit-select mux through a run of codes and packs the samples into one word.
// Latency: valid rises Nc cycles after the start edge. Start-to-start spacing is at least Nc+2 cycles.
// Backpressure: the word is held in HOLD with valid=1 until ready; start is ignored unless the block is idle.
// Optional feature: define MUX_SCAN_PARITY_EN to add the registered even-parity output.
module mux_scan_collector #(
  parameter int SEL_W = 5,
  parameter int N     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] first,
  input  logic [SEL_W:0]   count,
  output logic [SEL_W-1:0] opcode,
  input  logic             y,
  output logic             busy,
  output logic [N-1:0]     data,
  output logic             valid,
  input  logic             ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CW = SEL_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] opcode_q;
  logic [CW-1:0]    k_q;
  logic [CW-1:0]    nc_q;
  logic [CW-1:0]    nc_d;
  logic [N-1:0]     data_q;
  logic             valid_q;
  logic             busy_q;
`ifdef MUX_SCAN_PARITY_EN
  logic             parity_q;
`endif

  // Saturate the requested count: 0 and anything above N mean a full word.
  always_comb begin
    nc_d = count;
    if (count == '0 || count > CW'(N)) begin
      nc_d = CW'(N);
    end
  end

  // Scan sequencer: load on start, one sample per cycle, hold the word until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      k_q      <= '0;
      nc_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opcode_q <= first;
            k_q      <= '0;
            nc_q     <= nc_d;
            data_q   <= '0;
            busy_q   <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          // y reflects the opcode driven during the cycle that is ending now.
          data_q[k_q[SEL_W-1:0]] <= y;
          k_q      <= k_q + CW'(1);
          opcode_q <= opcode_q + SEL_W'(1);
`ifdef MUX_SCAN_PARITY_EN
          // Unwritten bits stay 0, so a running XOR equals the parity of the whole word.
          parity_q <= parity_q ^ y;
`endif
          if (k_q == nc_q - CW'(1)) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // A start seen on the handshake edge is dropped, not queued.
          if (ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign opcode = opcode_q;
  assign busy   = busy_q;
  assign data   = data_q;
  assign valid  = valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_collector.sv
// tb_mux_scan_collector: directed vectors against a behavioural 32:1 mux feeding the collector.
// Latency: outputs are sampled on the falling edge, half a cycle after each active edge.
// Backpressure: ready is driven low for a stretch of HOLD cycles.
module tb_mux_scan_collector;

  logic        clk;
  logic        rst_n;
  logic        start_r;
  logic [4:0]  first_r;
  logic [5:0]  count_r;
  logic [4:0]  opcode;
  logic        y;
  logic        busy;
  logic [31:0] data;
  logic        valid;
  logic        ready_r;
  logic [31:0] mux_in;
`ifdef MUX_SCAN_PARITY_EN
  logic        parity;
`endif

  int n_vec;
  int n_err;

  mux_scan_collector #(.SEL_W(5), .N(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_r),
    .first  (first_r),
    .count  (count_r),
    .opcode (opcode),
    .y      (y),
    .busy   (busy),
    .data   (data),
    .valid  (valid),
    .ready  (ready_r)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  // Behavioural upstream mux: combinational select of one input bit.
  assign y = mux_in[opcode];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_par(input string tag, input logic exp);
`ifdef MUX_SCAN_PARITY_EN
    chk(tag, {31'd0, parity}, {31'd0, exp});
`endif
  endtask

  // Start a run, check the opcode walk, then check the held word in the first HOLD cycle.
  task automatic run_scan(input string tag, input logic [4:0] f, input logic [5:0] c,
                          input int nc, input logic [31:0] exp_d, input logic exp_p);
    logic [4:0] e_op;
    @(negedge clk);
    first_r = f;
    count_r = c;
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    for (int j = 0; j < nc; j++) begin
      @(negedge clk);
      e_op = f + 5'(j);
      chk({tag, "_op"}, {27'd0, opcode}, {27'd0, e_op});
      if (j == 0) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (j == nc - 1) chk({tag, "_vld_early"}, {31'd0, valid}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, valid}, 32'd1);
    chk({tag, "_dat"}, data, exp_d);
    chk_par({tag, "_par"}, exp_p);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start_r = 1'b0;
    first_r = 5'd0;
    count_r = 6'd0;
    ready_r = 1'b1;
    mux_in  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_op", {27'd0, opcode}, 32'd0);
    chk("rst_dat", data, 32'd0);
    chk("rst_vld", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_par("rst_par", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full run, count 0 saturates to 32; 16 ones -> even parity 0
    mux_in = 32'hA5C3_0F96;
    run_scan("full", 5'd0, 6'd0, 32, 32'hA5C3_0F96, 1'b0);
    @(negedge clk);
    chk("full_vld_fall", {31'd0, valid}, 32'd0);
    chk("full_busy_fall", {31'd0, busy}, 32'd0);
    chk("full_dat_keep", data, 32'hA5C3_0F96);

    // Wrap-around: opcodes 30,31,0,1 sample 0,1,1,0
    mux_in = 32'h8000_0001;
    run_scan("wrap", 5'd30, 6'd4, 4, 32'h0000_0006, 1'b0);
    @(negedge clk);

    // Backpressure: 0xB5 has five ones -> parity 1
    ready_r = 1'b0;
    mux_in  = 32'h0000_00B5;
    run_scan("bp", 5'd0, 6'd8, 8, 32'h0000_00B5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_vld", {31'd0, valid}, 32'd1);
      chk("bp_hold_dat", data, 32'h0000_00B5);
      start_r = (i == 4);
      first_r = 5'd3;
      count_r = 6'd2;
    end
    chk_par("bp_hold_par", 1'b1);
    // Raise ready together with start: the start on the handshake edge must be dropped.
    ready_r = 1'b1;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk("bp_hs_vld", {31'd0, valid}, 32'd0);
    chk("bp_hs_busy", {31'd0, busy}, 32'd0);
    chk("bp_hs_dat", data, 32'h0000_00B5);
    @(negedge clk);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);

    // Short run with start held: a new run every 3 cycles
    mux_in  = 32'h0000_0020;
    first_r = 5'd5;
    count_r = 6'd1;
    start_r = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("short_busy", {31'd0, busy}, {31'd0, (c % 3) != 2});
      chk("short_vld", {31'd0, valid}, {31'd0, (c % 3) == 1});
      if (c == 1) chk("short_dat", data, 32'h0000_0001);
      if (c == 3) chk("short_dat_clr", data, 32'h0000_0000);
      if (c == 5) start_r = 1'b0;
    end
    @(negedge clk);
    chk("short_stop", {31'd0, busy}, 32'd0);

    // Reset mid-scan: count 40 saturates to 32, abort after 10 samples
    mux_in  = 32'hA5C3_0F96;
    first_r = 5'd0;
    count_r = 6'd40;
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_op", {27'd0, opcode}, 32'd0);
    chk("mid_rst_dat", data, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_vld", {31'd0, valid}, 32'd0);
    chk_par("mid_rst_par", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery run, count 63 saturates to 32; 0x12345678 has 13 ones -> parity 1
    mux_in = 32'h1234_5678;
    run_scan("recov", 5'd0, 6'd63, 32, 32'h1234_5678, 1'b1);
    @(negedge clk);
    chk("recov_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
